// File: rtl/cond_unit_if.sv
// Decoder/ALU <-> conditional-execution unit bus: instruction controls in, gated strobes and flags out.
interface cond_unit_if;
    logic       en;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic [3:0] ALUFlags;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    modport master (
        output en, Cond, FlagW, ALUFlags, PCS, RegW, MemW, NoWrite,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags
    );

    modport slave (
        input  en, Cond, FlagW, ALUFlags, PCS, RegW, MemW, NoWrite,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags
    );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field against the
// registered flags and gates the PC/register/memory write strobes.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    cond_unit_if.slave   bus
);
    localparam int unsigned FLAG_W = 4;

    logic [FLAG_W-1:0] flags_q;
    logic              n, z, c, v;
    logic              cond_pass;
    logic              cond_ex;

    assign {n, z, c, v} = flags_q;

    // Condition decode uses only the registered flags; ALUFlags never bypass into it.
    always_comb begin
        cond_pass = 1'b0;
        unique case (bus.Cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex      = bus.en & cond_pass & ~reset;
    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.RegWrite = bus.RegW & ~bus.NoWrite & cond_ex;
    assign bus.Flags    = flags_q;

    // FlagW[1] selects N/Z, FlagW[0] selects C/V; unselected halves hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
        end else if (cond_ex) begin
            if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the ARM datapath. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. It gates the register-write, memory-write and PC-source strobes accordingly, and captures new ALU flags when the instruction executes and requests a flag update. It is the consumer of the ALU's 4-bit `{N,Z,C,V}` flag bus and sits between the control decoder and the register file, memory and PC logic.

## Interface
- `RESET_FLAGS`, default 4'b0000: value loaded into the flag register on reset, ordered `{N,Z,C,V}`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `en`  in  1: instruction in this stage is valid. When low, the unit suppresses all strobes and updates no flags.
- `Cond`  in  4: instruction condition field, bits [31:28].
- `FlagW`  in  2: flag write request. Bit 1 updates N and Z; bit 0 updates C and V.
- `ALUFlags`  in  4: `{N,Z,C,V}` from the ALU for the current instruction.
- `PCS`  in  1: decoder requests a PC write (branch, or a write to R15).
- `RegW`  in  1: decoder requests a register-file write.
- `MemW`  in  1: decoder requests a memory write.
- `NoWrite`  in  1: compare-class instruction (CMP/CMN/TST/TEQ); suppresses the register write.
- `CondEx`  out  1: condition passed for the current instruction.
- `PCSrc`  out  1: gated PC write.
- `RegWrite`  out  1: gated register write.
- `MemWrite`  out  1: gated memory write.
- `Flags`  out  4: current contents of the flag register, `{N,Z,C,V}`.

## Operation
- **Flag register:** 4 bits, `{N,Z,C,V}`, bit 3 = N, bit 0 = V.
- **Condition evaluation** is combinational against the *registered* flags (N,Z,C,V below), never against `ALUFlags`:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C & ~Z. 1001 LS: ~C | Z.
  - 1010 GE: N == V. 1011 LT: N != V.
  - 1100 GT: ~Z & (N == V). 1101 LE: Z | (N != V).
  - 1110 AL: 1.
  - 1111: reserved, CondEx = 0 (instruction suppressed).
- **CondEx output:** CondEx = en & cond_pass & ~reset.
- **Strobes:**
  - PCSrc = PCS & CondEx.
  - MemWrite = MemW & CondEx.
  - RegWrite = RegW & ~NoWrite & CondEx.
- **Flag update** happens at the rising edge when ~reset & CondEx:
  - FlagW[1] = 1: N ← ALUFlags[3], Z ← ALUFlags[2].
  - FlagW[0] = 1: C ← ALUFlags[1], V ← ALUFlags[0].
  - Bits not selected by FlagW hold their value.
  - FlagW = 2'b00: no change.
- A failed condition never updates flags, even when FlagW ≠ 0.
- **Priority:** reset > (en & CondEx) update > hold.
- The unit does no arithmetic. It only selects bits and applies boolean gating.

## Timing
- **Reset:** asserting `reset` at an edge loads Flags = RESET_FLAGS at that edge. While reset is high, CondEx, PCSrc, RegWrite and MemWrite are 0 combinationally. After reset deasserts, Flags = RESET_FLAGS until the first qualifying update.
- **Latency:**
  - Strobes and CondEx are combinational from inputs and the current Flags, valid in the same cycle.
  - A flag update is visible on `Flags` one cycle after the instruction that sets it.
- **Back-to-back:** the instruction in cycle k+1 evaluates its condition against the flags written by the instruction in cycle k (e.g. CMP then BEQ). No bypass of `ALUFlags` into evaluation in the same cycle.
- **Mid-stream reset:** reset in the same cycle as a flag-setting instruction. Reset wins, flags become RESET_FLAGS, and all strobes are 0 that cycle.
- **en low:** strobes are 0 and flags hold, regardless of Cond and FlagW.
- There is no handshake; one instruction is evaluated per cycle while `en` is high.

## Test plan
- **Reset:** reset=1 for 2 cycles with RESET_FLAGS=4'b0000, Cond=1110, RegW=1, en=1 → RegWrite=0 during reset, Flags=0000. Next cycle with reset=0 → RegWrite=1.
- **CMP then BEQ:**
  - Cycle 0: Cond=1110, FlagW=11, ALUFlags=0100, NoWrite=1, RegW=1 → RegWrite=0.
  - Cycle 1: Flags=0100; Cond=0000, PCS=1 → PCSrc=1.
  - Repeat with ALUFlags=0000 → PCSrc=0 in cycle 1.
- **Partial update:** Flags=1111. Apply FlagW=10, ALUFlags=0000, Cond=1110 → Flags=0011 next cycle. Then FlagW=01, ALUFlags=0000 → Flags=0000.
- **Failed condition:** Flags=0100 (Z=1), Cond=0001 (NE), FlagW=11, ALUFlags=1010, MemW=1, RegW=1 → CondEx=0, MemWrite=0, RegWrite=0, Flags stays 0100.
- **Signed compares:** sweep all 16 Flags values × all 16 Cond values with en=1, PCS=1 → PCSrc matches the condition table in Operation. Spot checks: Flags=1001 GE→1, LT→0; Flags=0101 GT→0, LE→1; Cond=1111 → 0 for every Flags value.
- **en gating and reset priority:**
  - en=0, Cond=1110, FlagW=11, ALUFlags=1111 → all strobes 0, Flags unchanged.
  - reset=1 with the same stimulus and en=1 → Flags=RESET_FLAGS.
